// File: rtl/noc_pkg.sv
// noc_pkg: mesh router sizing, port direction encoding and switch allocator state type.
package noc_pkg;
   localparam int PORTS = 5;
   localparam int PORT_W = 3;
   localparam int PORT_N = 0;
   localparam int PORT_E = 1;
   localparam int PORT_S = 2;
   localparam int PORT_W_DIR = 3;
   localparam int PORT_LOCAL = 4;
   typedef enum logic {IDLE, LOCKED} out_state_e;
endpackage

// File: rtl/sw_arbiter_rr_arb.sv
// rr_arb: combinational one-hot round-robin pick, searching from ptr_i+1 upward with wrap.
module rr_arb #(
   parameter int N = 5,
   parameter int W = 3
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o
);
   logic [W-1:0] idx;
   always_comb begin
      gnt_o = '0;
      idx = '0;
      // Walk farthest-first so the nearest requester after the pointer wins last.
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(ptr_i) + k) % N);
         if (req_i[idx]) begin
            gnt_o = '0;
            gnt_o[idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sw_arbiter.sv
// sw_arbiter: per-output round-robin switch allocator with head-to-tail packet locking.
// Define SW_ARB_PERF_EN to add saturating per-output flit counters on perf_cnt_o.
module sw_arbiter #(
   parameter int PORTS = noc_pkg::PORTS,
   parameter int PORT_W = noc_pkg::PORT_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [PORTS-1:0]               req_i,
   input  logic [PORTS-1:0][PORT_W-1:0]   port_i,
   input  logic [PORTS-1:0]               head_i,
   input  logic [PORTS-1:0]               tail_i,
   input  logic [PORTS-1:0]               out_rdy_i,
   output logic [PORTS-1:0]               grant_o,
   output logic [PORTS-1:0]               out_vld_o,
   output logic [PORTS-1:0][PORT_W-1:0]   sel_o
`ifdef SW_ARB_PERF_EN
   ,
   output logic [PORTS-1:0][15:0]         perf_cnt_o
`endif
);
   import noc_pkg::*;

   out_state_e                 state_q [PORTS];
   out_state_e                 state_d [PORTS];
   logic [PORTS-1:0][PORT_W-1:0] owner_q, owner_d, ptr_q, ptr_d, sel_q, sel_d, win_idx;
   logic [PORTS-1:0][PORTS-1:0]  cand, win;
   logic [PORTS-1:0]             nonhead_idle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '{default: IDLE};
         owner_q <= '0;
         ptr_q   <= {PORTS{PORT_W'(PORTS - 1)}};
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
      end
   end

   // An idle output only takes heads; a locked one only its owner, head or not.
   always_comb begin
      cand = '0;
      nonhead_idle = '0;
      for (int j = 0; j < PORTS; j++) begin
         for (int i = 0; i < PORTS; i++) begin
            cand[j][i] = req_i[i] && port_i[i] == PORT_W'(j) && out_rdy_i[j] &&
                         (state_q[j] == IDLE ? head_i[i] : owner_q[j] == PORT_W'(i));
            nonhead_idle[j] = nonhead_idle[j] |
                              (req_i[i] && port_i[i] == PORT_W'(j) && state_q[j] == IDLE && !head_i[i]);
         end
      end
   end

   for (genvar j = 0; j < PORTS; j++) begin : g_arb
      rr_arb #(.N(PORTS), .W(PORT_W)) u_rr (
         .req_i (cand[j]),
         .ptr_i (ptr_q[j]),
         .gnt_o (win[j])
      );
      assert property (@(posedge clk) disable iff (!rst_n) !nonhead_idle[j]);
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d = ptr_q;
      for (int j = 0; j < PORTS; j++) begin
         if (out_vld_o[j]) begin
            if (state_q[j] == IDLE) begin
               if (tail_i[win_idx[j]]) ptr_d[j] = win_idx[j];
               else begin
                  state_d[j] = LOCKED;
                  owner_d[j] = win_idx[j];
               end
            end else if (tail_i[owner_q[j]]) begin
               state_d[j] = IDLE;
               ptr_d[j] = owner_q[j];
            end
         end
      end
   end

   always_comb begin
      grant_o = '0;
      out_vld_o = '0;
      win_idx = '0;
      sel_d = sel_q;
      for (int j = 0; j < PORTS; j++) begin
         out_vld_o[j] = |win[j];
         grant_o = grant_o | win[j];
         for (int i = 0; i < PORTS; i++) if (win[j][i]) win_idx[j] = PORT_W'(i);
         sel_d[j] = out_vld_o[j] ? win_idx[j] : sel_q[j];
      end
      sel_o = sel_d;
   end

`ifdef SW_ARB_PERF_EN
   logic [PORTS-1:0][15:0] perf_q, perf_d;
   always_comb begin
      perf_d = perf_q;
      for (int j = 0; j < PORTS; j++)
         perf_d[j] = perf_q[j] + 16'(out_vld_o[j] && perf_q[j] != 16'hFFFF);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_q <= '0;
      else perf_q <= perf_d;
   end
   assign perf_cnt_o = perf_q;
`endif
endmodule

// File: tb/tb_sw_arbiter.sv
// tb_sw_arbiter: directed checks of reset, fairness, locking, backpressure, parallel grants and mid-packet reset.
module tb_sw_arbiter;
   import noc_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] req, head, tail, rdy, grant, vld;
   logic [4:0][2:0] port, sel;
`ifdef SW_ARB_PERF_EN
   logic [4:0][15:0] perf;
`endif
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sw_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .port_i    (port),
      .head_i    (head),
      .tail_i    (tail),
      .out_rdy_i (rdy),
      .grant_o   (grant),
      .out_vld_o (vld),
      .sel_o     (sel)
`ifdef SW_ARB_PERF_EN
      ,
      .perf_cnt_o (perf)
`endif
   );

   task automatic clr();
      req = '0; head = '0; tail = '0; rdy = '1; port = '0;
   endtask

   task automatic flit(input int i, input int p, input logic h, input logic t);
      req[i] = 1'b1; port[i] = 3'(p); head[i] = h; tail[i] = t;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      checks++;
      if (grant !== 5'b0 || vld !== 5'b0 || sel !== 15'b0) begin
         failures++;
         $display("FAIL reset_held grant=%b vld=%b sel=%h", grant, vld, sel);
      end
      @(negedge clk); rst_n = 1'b1; #1;
      checks++;
      if (grant !== 5'b0) begin failures++; $display("FAIL reset_grant got=%b exp=00000", grant); end
      checks++;
      if (vld !== 5'b0) begin failures++; $display("FAIL reset_vld got=%b exp=00000", vld); end
      checks++;
      if (sel !== 15'b0) begin failures++; $display("FAIL reset_sel got=%h exp=0", sel); end
   endtask

   task automatic test_fairness();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); clr();
         flit(0, PORT_LOCAL, 1, 1); flit(1, PORT_LOCAL, 1, 1); flit(2, PORT_LOCAL, 1, 1);
         #1;
         checks++;
         if (grant !== 5'(1 << (c % 3)) || vld !== 5'b10000) begin
            failures++;
            $display("FAIL fair_grant c=%0d grant=%b vld=%b exp_grant=%b", c, grant, vld, 5'(1 << (c % 3)));
         end
         checks++;
         if (sel[4] !== 3'(c % 3)) begin failures++; $display("FAIL fair_sel c=%0d got=%0d exp=%0d", c, sel[4], c % 3); end
      end
   endtask

   task automatic test_locking();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); clr();
         if (c < 4) flit(3, PORT_E, c == 0, c == 3);
         if (c > 0) flit(0, PORT_E, 1, 1);
         #1;
         checks++;
         if (grant !== (c < 4 ? 5'b01000 : 5'b00001) || sel[1] !== (c < 4 ? 3'd3 : 3'd0)) begin
            failures++;
            $display("FAIL lock c=%0d grant=%b sel1=%0d", c, grant, sel[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk); clr(); flit(1, PORT_S, 1, 0); #1;
      checks++;
      if (grant !== 5'b00010) begin failures++; $display("FAIL bp_head got=%b exp=00010", grant); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); clr(); rdy[2] = 1'b0; flit(1, PORT_S, 0, 0); flit(0, PORT_S, 1, 1); #1;
         checks++;
         if (grant !== 5'b0 || vld !== 5'b0 || sel[2] !== 3'd1) begin
            failures++;
            $display("FAIL bp_stall c=%0d grant=%b vld=%b sel2=%0d", c, grant, vld, sel[2]);
         end
      end
      @(negedge clk); clr(); flit(1, PORT_S, 0, 0); flit(0, PORT_S, 1, 1); #1;
      checks++;
      if (grant !== 5'b00010) begin failures++; $display("FAIL bp_resume got=%b exp=00010", grant); end
      @(negedge clk); clr(); flit(1, PORT_S, 0, 1); flit(0, PORT_S, 1, 1); #1;
      checks++;
      if (grant !== 5'b00010) begin failures++; $display("FAIL bp_tail got=%b exp=00010", grant); end
      @(negedge clk); clr(); flit(0, PORT_S, 1, 1); #1;
      checks++;
      if (grant !== 5'b00001 || sel[2] !== 3'd0) begin
         failures++;
         $display("FAIL bp_next grant=%b sel2=%0d exp=00001/0", grant, sel[2]);
      end
   endtask

   task automatic test_parallel();
      logic [4:0][2:0] exp_sel;
      @(negedge clk); clr();
      for (int i = 0; i < 5; i++) flit(i, (i + 1) % 5, 1, 1);
      for (int j = 0; j < 5; j++) exp_sel[j] = 3'((j + 4) % 5);
      #1;
      checks++;
      if (grant !== 5'b11111 || vld !== 5'b11111) begin
         failures++;
         $display("FAIL par_grant grant=%b vld=%b exp=11111", grant, vld);
      end
      checks++;
      if (sel !== exp_sel) begin failures++; $display("FAIL par_sel got=%h exp=%h", sel, exp_sel); end
   endtask

   task automatic test_bad_port();
      @(negedge clk); clr(); flit(2, 5, 1, 1); flit(3, 7, 1, 1); #1;
      checks++;
      if (grant !== 5'b0 || vld !== 5'b0) begin
         failures++;
         $display("FAIL bad_port grant=%b vld=%b exp=0/0", grant, vld);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk); clr(); flit(2, PORT_E, 1, 0); #1;
      checks++;
      if (grant !== 5'b00100 || sel[1] !== 3'd2) begin
         failures++;
         $display("FAIL mr_lock grant=%b sel1=%0d exp=00100/2", grant, sel[1]);
      end
      @(negedge clk); clr(); rst_n = 1'b0; #1;
      checks++;
      if (grant !== 5'b0 || vld !== 5'b0 || sel !== 15'b0) begin
         failures++;
         $display("FAIL mr_in_reset grant=%b vld=%b sel=%h", grant, vld, sel);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); clr(); flit(0, PORT_E, 1, 1); flit(1, PORT_E, 1, 1); #1;
      checks++;
      if (grant !== 5'b00001 || vld !== 5'b00010 || sel[1] !== 3'd0) begin
         failures++;
         $display("FAIL mr_after grant=%b vld=%b sel1=%0d exp=00001/00010/0", grant, vld, sel[1]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      test_reset();
      test_fairness();
      test_locking();
      test_backpressure();
      test_parallel();
      test_bad_port();
      test_mid_reset();
      @(negedge clk); clr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sw_arbiter.md
# sw_arbiter

Switch allocator for the 5-port XY mesh router. It takes each input port's requested output port, as produced by the route computation stage, and grants every output port to at most one input per cycle. Selection is round-robin, with packet-level locking from head to tail flit. It sits between the per-input route-compute/buffer stage and the crossbar, and drives the crossbar select lines.

## Interface
Parameters:
- PORTS, 5, number of input and output ports.
- PORT_W, 3, width of a port index.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  PORTS  input i presents a valid flit.
- port_i  in  PORTS x PORT_W  requested output for input i; valid when req_i[i].
- head_i  in  PORTS  flit on input i is a head flit.
- tail_i  in  PORTS  flit on input i is a tail flit. Head and tail together mean a single-flit packet.
- out_rdy_i  in  PORTS  output j can accept a flit this cycle (credit available).
- grant_o  out  PORTS  input i's flit is transferred this cycle; the input pops it.
- out_vld_o  out  PORTS  output j carries a flit this cycle.
- sel_o  out  PORTS x PORT_W  crossbar select: source input index for output j.

## Operation
- Each output j has a 2-state FSM, IDLE or LOCKED, plus owner_q[j] (PORT_W bits) and ptr_q[j] (last-served input, PORT_W bits).
- Candidate set for output j: inputs i with req_i[i], port_i[i]==j and out_rdy_i[j].
- IDLE: only head flits are candidates. Pick the first candidate after ptr_q[j] in the order ptr+1, ptr+2, … wrapping modulo PORTS.
  - Grant with head and not tail: go to LOCKED, owner_q[j]=i.
  - Grant with head and tail: stay IDLE, ptr_q[j]=i.
- LOCKED: only owner_q[j] is a candidate, regardless of head_i.
  - Granted tail: go to IDLE, ptr_q[j]=owner_q[j].
  - No request or out_rdy_i[j]=0: hold LOCKED, no grant.
- out_vld_o[j]=1 and sel_o[j]=winner in the grant cycle. Otherwise out_vld_o[j]=0 and sel_o[j] holds its last value.
- grant_o[i] is the OR over outputs of "i won j". Each input requests one output, so at most one grant per input.
- port_i values >= PORTS are ignored: no grant.
- A non-head flit requesting an IDLE output is never granted. This is a protocol error and is only flagged by an assertion.
- Different outputs arbitrate independently in the same cycle.

## Timing
- Grant is combinational: req_i/port_i/out_rdy_i to grant_o/out_vld_o/sel_o in the same cycle. FSM, owner and pointer update on the following clk edge.
- Reset values:
  - all FSMs IDLE;
  - ptr_q = PORTS-1, so input 0 has first priority;
  - owner_q = 0, sel_o = 0;
  - grant_o = 0, out_vld_o = 0.
- Throughput: one flit per output per cycle. A lock releases on the tail cycle, and a new head may be granted the next cycle.
- Reset mid-packet drops all locks immediately. Upstream buffers are reset together with this block.

## Configuration
- SW_ARB_PERF_EN defined:
  - adds output perf_cnt_o, PORTS x 16 bits;
  - per-output flit counter increments on each out_vld_o[j];
  - saturates at 16'hFFFF;
  - reset to 0.
- Not defined: port and counters absent. Arbitration behaviour is identical either way.

## Structure
- noc_pkg holds:
  - PORTS and PORT_W;
  - port encoding constants PORT_N=0, PORT_E=1, PORT_S=2, PORT_W_DIR=3, PORT_LOCAL=4;
  - the output FSM enum typedef (IDLE, LOCKED).
- Sub-module rr_arb: PORTS-wide one-hot round-robin pick from a request vector and pointer. Instantiated once per output; it is pure combinational. The pointer register stays in sw_arbiter.

## Test plan
- Reset: after rst_n release, all requests 0 → grant_o=0, out_vld_o=0, sel_o=0.
- Fairness: inputs 0, 1, 2 each send single-flit packets to output 4 every cycle, out_rdy=1 → grants rotate 0,1,2,0,1,2. sel_o[4] follows.
- Locking: input 3 sends a head, 2 body flits and a tail to output 1, while input 0 requests output 1 with a head → input 3 granted 4 consecutive cycles. Input 0 granted in cycle 5.
- Backpressure: output 2 LOCKED to input 1, out_rdy_i[2]=0 for 3 cycles → no grant, state held. Resumes on out_rdy=1.
- Parallel outputs: input 0→1, 1→2, 2→3, 3→4 and 4→0, all single-flit, all ready → all five grants in the same cycle.
- Mid-packet reset: rst_n pulsed while output 1 is LOCKED → output 1 returns to IDLE, and the next head from any input is granted with ptr = PORTS-1.
